// File: rtl/bus_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bus_arb_pkg
// Purpose  : Shared state encoding, widths and round-robin pick helper for
//            the 4-way bus arbiter.
// Revision : 1.0  initial release
// ============================================================================
package bus_arb_pkg;

    localparam int HOLD_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } arb_state_e;

    // First requester found scanning last+1, last+2, ... (mod 4).
    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
        logic [1:0] w_idx;
        logic [1:0] w_pick;
        logic       w_found;
        w_pick  = 2'd0;
        w_found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            w_idx = last + 2'(k);
            if (!w_found && req[w_idx]) begin
                w_pick  = w_idx;
                w_found = 1'b1;
            end
        end
        return w_pick;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bus_arbiter4_demux4.sv
`default_nettype none
// ============================================================================
// Module   : demux4
// Purpose  : Active-low 1-of-4 demultiplexer; the selected output follows
//            in_n, all others stay high.
// Revision : 1.0  initial release
// ============================================================================
module demux4 #(
    parameter int BITS = 1
) (
    input  logic [BITS-1:0] in_n,
    input  logic            s1,
    input  logic            s2,
    output logic [BITS-1:0] out1_n,
    output logic [BITS-1:0] out2_n,
    output logic [BITS-1:0] out3_n,
    output logic [BITS-1:0] out4_n
);

    always_comb begin
        out1_n = '1;
        out2_n = '1;
        out3_n = '1;
        out4_n = '1;
        case ({s2, s1})
            2'd0:    out1_n = in_n;
            2'd1:    out2_n = in_n;
            2'd2:    out3_n = in_n;
            default: out4_n = in_n;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/bus_arbiter4.sv
`default_nettype none
// ============================================================================
// Module   : bus_arbiter4
// Purpose  : Round-robin 4-way arbiter with one-cycle turnaround and optional
//            maximum hold time under contention.
// Revision : 1.0  initial release
// ============================================================================
module bus_arbiter4 #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    output logic [3:0] grant_n,
    output logic [1:0] owner,
    output logic       busy
);
    import bus_arb_pkg::*;

    localparam bit              c_hold_en   = (MAX_HOLD != 0);
    localparam logic [HOLD_W-1:0] c_hold_last = HOLD_W'(MAX_HOLD - 1);
    localparam logic [HOLD_W-1:0] c_hold_max  = '1;

    arb_state_e        r_state_q, w_state_d;
    logic [1:0]        r_last_q,  w_last_d;
    logic [1:0]        r_owner_q, w_owner_d;
    logic [HOLD_W-1:0] r_hold_q,  w_hold_d;

    logic [1:0] w_win;
    logic       w_others;
    logic       w_release;
    logic       w_grant_in_n;

    assign w_win     = rr_pick(req, r_last_q);
    assign w_others  = |(req & ~(4'b0001 << r_owner_q));
    // A lone requester is never preempted: the limit only bites when someone waits.
    assign w_release = ~req[r_owner_q]
                     | (c_hold_en && (r_hold_q == c_hold_last) && w_others);

    always_comb begin
        w_state_d = r_state_q;
        w_last_d  = r_last_q;
        w_owner_d = r_owner_q;
        w_hold_d  = r_hold_q;
        case (r_state_q)
            IDLE, TURN: begin
                if (|req) begin
                    w_state_d = GRANT;
                    w_owner_d = w_win;
                    w_last_d  = w_win;
                    w_hold_d  = '0;
                end else begin
                    w_state_d = IDLE;
                end
            end
            GRANT: begin
                if (r_hold_q != c_hold_max) begin
                    w_hold_d = r_hold_q + HOLD_W'(1);
                end
                if (w_release) begin
                    w_state_d = TURN;
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q <= IDLE;
            r_last_q  <= 2'd3;
            r_owner_q <= 2'd0;
            r_hold_q  <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_last_q  <= w_last_d;
            r_owner_q <= w_owner_d;
            r_hold_q  <= w_hold_d;
        end
    end

    assign w_grant_in_n = ~(r_state_q == GRANT);

    demux4 #(.BITS(1)) u_demux (
        .in_n   (w_grant_in_n),
        .s1     (r_owner_q[0]),
        .s2     (r_owner_q[1]),
        .out1_n (grant_n[0]),
        .out2_n (grant_n[1]),
        .out3_n (grant_n[2]),
        .out4_n (grant_n[3])
    );

    assign owner = r_owner_q;
    assign busy  = (r_state_q == GRANT);

`ifdef FORMAL
    always_comb begin
        if (!reset) begin
            assert ($countones(~grant_n) <= 1);
            assert (busy == ~&grant_n);
            assert ((grant_n == 4'b1111) || (r_state_q == GRANT));
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter4.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_arbiter4
// Purpose  : Directed self-checking bench for bus_arbiter4 (MAX_HOLD=4 and 1).
// Revision : 1.0  initial release
// ============================================================================
module tb_bus_arbiter4;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic [3:0] req1;
    logic [3:0] grant_n;
    logic [3:0] grant1_n;
    logic [1:0] owner;
    logic [1:0] owner1;
    logic       busy;
    logic       busy1;

    int pass_cnt;
    int total_cnt;

    localparam logic [3:0] c_hold4_seq [0:10] = '{
        4'b1110, 4'b1110, 4'b1110, 4'b1110, 4'b1111,
        4'b1101, 4'b1101, 4'b1101, 4'b1101, 4'b1111, 4'b1110
    };
    localparam logic [3:0] c_hold1_seq [0:10] = '{
        4'b1110, 4'b1111, 4'b1101, 4'b1111, 4'b1110,
        4'b1111, 4'b1101, 4'b1111, 4'b1110, 4'b1111, 4'b1101
    };

    bus_arbiter4 #(.MAX_HOLD(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .grant_n (grant_n),
        .owner   (owner),
        .busy    (busy)
    );

    bus_arbiter4 #(.MAX_HOLD(1)) dut1 (
        .clk     (clk),
        .reset   (reset),
        .req     (req1),
        .grant_n (grant1_n),
        .owner   (owner1),
        .busy    (busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = 4'b0000;
        req1  = 4'b0000;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req   = 4'b1111;
        req1  = 4'b0000;
        for (int c = 0; c < 2; c++) begin
            step();
            total_cnt++;
            if ({grant_n, busy, owner} !== {4'b1111, 1'b0, 2'd0})
                $display("FAIL reset c=%0d: grant_n=%b busy=%b owner=%0d, want 1111/0/0", c, grant_n, busy, owner);
            else
                pass_cnt++;
        end
        reset = 1'b0;
        req   = 4'b0000;
        step();
        total_cnt++;
        if ({grant_n, busy} !== {4'b1111, 1'b0})
            $display("FAIL reset_idle: grant_n=%b busy=%b, want 1111/0", grant_n, busy);
        else
            pass_cnt++;
    endtask

    task automatic test_single();
        req = 4'b0001;
        for (int c = 1; c <= 3; c++) begin
            step();
            total_cnt++;
            if ({grant_n, busy, owner} !== {4'b1110, 1'b1, 2'd0})
                $display("FAIL single c=%0d: grant_n=%b busy=%b owner=%0d, want 1110/1/0", c, grant_n, busy, owner);
            else
                pass_cnt++;
        end
        req = 4'b0000;
        for (int c = 4; c <= 5; c++) begin
            step();
            total_cnt++;
            if ({grant_n, busy} !== {4'b1111, 1'b0})
                $display("FAIL single_release c=%0d: grant_n=%b busy=%b, want 1111/0", c, grant_n, busy);
            else
                pass_cnt++;
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_owner;
        logic [3:0] exp_gn;
        do_reset();
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            exp_owner = 2'(g);
            exp_gn    = ~(4'b0001 << exp_owner);
            step();
            total_cnt++;
            if ({grant_n, owner, busy} !== {exp_gn, exp_owner, 1'b1})
                $display("FAIL rr_grant g=%0d: grant_n=%b owner=%0d busy=%b, want %b/%0d/1", g, grant_n, owner, busy, exp_gn, exp_owner);
            else
                pass_cnt++;
            req[exp_owner] = 1'b0;
            step();
            total_cnt++;
            if ({grant_n, busy} !== {4'b1111, 1'b0})
                $display("FAIL rr_gap g=%0d: grant_n=%b busy=%b, want 1111/0", g, grant_n, busy);
            else
                pass_cnt++;
            req = 4'b1111;
        end
        req = 4'b0000;
        step();
        step();
    endtask

    task automatic test_hold_limit();
        do_reset();
        req  = 4'b0011;
        req1 = 4'b0011;
        for (int c = 0; c < 11; c++) begin
            step();
            total_cnt++;
            if (grant_n !== c_hold4_seq[c])
                $display("FAIL hold4 c=%0d: grant_n=%b, want %b", c, grant_n, c_hold4_seq[c]);
            else
                pass_cnt++;
            total_cnt++;
            if (grant1_n !== c_hold1_seq[c])
                $display("FAIL hold1 c=%0d: grant_n=%b, want %b", c, grant1_n, c_hold1_seq[c]);
            else
                pass_cnt++;
        end
        req  = 4'b0000;
        req1 = 4'b0000;
        step();
        step();
    endtask

    task automatic test_no_preempt();
        do_reset();
        req = 4'b0100;
        for (int c = 0; c < 20; c++) begin
            step();
            total_cnt++;
            if ({grant_n, owner} !== {4'b1011, 2'd2})
                $display("FAIL no_preempt c=%0d: grant_n=%b owner=%0d, want 1011/2", c, grant_n, owner);
            else
                pass_cnt++;
        end
    endtask

    task automatic test_midop_reset();
        total_cnt++;
        if ({busy, owner} !== {1'b1, 2'd2})
            $display("FAIL midop_pre: busy=%b owner=%0d, want 1/2", busy, owner);
        else
            pass_cnt++;
        reset = 1'b1;
        step();
        total_cnt++;
        if ({grant_n, busy, owner} !== {4'b1111, 1'b0, 2'd0})
            $display("FAIL midop_reset: grant_n=%b busy=%b owner=%0d, want 1111/0/0", grant_n, busy, owner);
        else
            pass_cnt++;
        reset = 1'b0;
        req   = 4'b0101;
        step();
        total_cnt++;
        if ({grant_n, busy, owner} !== {4'b1110, 1'b1, 2'd0})
            $display("FAIL midop_first: grant_n=%b busy=%b owner=%0d, want 1110/1/0", grant_n, busy, owner);
        else
            pass_cnt++;
        req = 4'b0100;
        step();
        step();
        total_cnt++;
        if ({grant_n, owner} !== {4'b1011, 2'd2})
            $display("FAIL midop_next: grant_n=%b owner=%0d, want 1011/2", grant_n, owner);
        else
            pass_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        reset     = 1'b1;
        req       = 4'b0000;
        req1      = 4'b0000;
        test_reset();
        test_single();
        test_round_robin();
        test_hold_limit();
        test_no_preempt();
        test_midop_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
